// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a single outstanding, abortable
// request to instruction memory, a one-entry hold buffer that catches a word
// returned while the hazard unit stalls IF/ID, and a redirect path that
// flushes everything in flight.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  // instruction memory side
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  // pipeline control
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  // IF/ID register
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;

  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;

  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc_q, hold_pc_d;

  logic [31:0] pc_plus4;
  logic [31:0] hold_pc_plus4;
  logic [31:0] redirect_pc_aligned;

  // 32-bit adders wrap naturally, so 0xFFFF_FFFC + 4 yields 0.
  assign pc_plus4            = pc_q + 32'd4;
  assign hold_pc_plus4       = hold_pc_q + 32'd4;
  assign redirect_pc_aligned = redirect_pc & ~32'h0000_0003;

  // A request is presented only while actively fetching; reset masks it
  // combinationally so memory never sees a request during reset.
  assign imem_req  = (state_q == FETCH) && !rst;
  assign imem_addr = pc_q;

  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;

  // Next-state logic for the fetch FSM, PC, IF/ID register and hold buffer.
  always_comb begin
    // NOTE: every variable gets a default here so no path can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    id_valid_d    = id_valid_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    hold_valid_d  = hold_valid_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;

    if (redirect) begin
      // A taken branch/jump overrides stall and any returned word: restart
      // fetching at the aligned target with an empty pipeline front.
      pc_d         = redirect_pc_aligned;
      id_valid_d   = 1'b0;
      hold_valid_d = 1'b0;
      state_d      = FETCH;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FETCH;
        end

        FETCH: begin
          if (stall) begin
            // IF/ID holds; a word that arrives now must not be lost, so park
            // it with its address and stop requesting until the stall clears.
            if (imem_ready) begin
              hold_valid_d = 1'b1;
              hold_instr_d = imem_rdata;
              hold_pc_d    = pc_q;
              state_d      = HOLD;
            end
          end else if (imem_ready) begin
            id_valid_d    = 1'b1;
            id_instr_d    = imem_rdata;
            id_pc_d       = pc_q;
            id_pc_plus4_d = pc_plus4;
            pc_d          = pc_plus4;
          end else begin
            // Memory not ready: hand ID a bubble and retry the same address.
            id_valid_d = 1'b0;
          end
        end

        HOLD: begin
          if (!stall) begin
            id_valid_d    = hold_valid_q;
            id_instr_d    = hold_instr_q;
            id_pc_d       = hold_pc_q;
            id_pc_plus4_d = hold_pc_plus4;
            pc_d          = hold_pc_plus4;
            hold_valid_d  = 1'b0;
            state_d       = FETCH;
          end
        end

        default: begin
          // Unused encoding: recover by restarting the fetch sequence.
          state_d      = IDLE;
          id_valid_d   = 1'b0;
          hold_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous reset that outranks every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      id_valid_q    <= 1'b0;
      id_instr_q    <= 32'h0;
      id_pc_q       <= 32'h0;
      id_pc_plus4_q <= 32'h0;
      // NOTE: the hold buffer payload is cleared too, not just its valid bit,
      // so no stale word is observable after reset.
      hold_valid_q  <= 1'b0;
      hold_instr_q  <= 32'h0;
      hold_pc_q     <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      id_valid_q    <= id_valid_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      hold_valid_q  <= hold_valid_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: scoreboard bench for if_stage. A behavioural model predicts,
// for every cycle, the fetch request and IF/ID contents; a separate monitor
// compares them against the DUT on the falling edge.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PATTERN  = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  always #5 clk = ~clk;

  // Memory returns a word derived from its address, so a wrong address shows.
  assign imem_rdata = imem_addr ^ PATTERN;

  if_stage #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_pc_plus4(id_pc_plus4)
  );

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic        cmp_fields;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } snap_t;

  snap_t exp_q[$];
  int    total = 0;
  int    bad   = 0;

  // Reference model: program counter, "just left reset" flag, optional
  // parked word, and what ID currently holds.
  logic [31:0] m_pc;
  bit          m_idle;
  bit          m_buf_full;
  logic [31:0] m_buf_instr;
  logic [31:0] m_buf_pc;
  bit          m_vld;
  bit          m_zero;
  logic [31:0] m_instr;
  logic [31:0] m_idpc;
  logic [31:0] m_idpc4;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a ^ PATTERN;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc       = RESET_PC;
    m_idle     = 1'b1;
    m_buf_full = 1'b0;
    m_vld      = 1'b0;
    m_zero     = 1'b1;
    m_instr    = 32'h0;
    m_idpc     = 32'h0;
    m_idpc4    = 32'h0;
  endtask

  task automatic model_deliver(input logic [31:0] w, input logic [31:0] a);
    m_vld   = 1'b1;
    m_zero  = 1'b0;
    m_instr = w;
    m_idpc  = a;
    m_idpc4 = a + 32'd4;
  endtask

  // One clock cycle: drive inputs, record what the DUT must show during this
  // cycle, then advance the model across the coming rising edge.
  task automatic cycle(input logic r, input logic s, input logic rd,
                       input logic [31:0] rpc, input logic rdy);
    snap_t e;
    @(posedge clk);
    #1;
    rst = r; stall = s; redirect = rd; redirect_pc = rpc; imem_ready = rdy;

    e.req        = !r && !m_idle && !m_buf_full;
    e.addr       = m_pc;
    e.vld        = m_vld;
    e.cmp_fields = m_vld || m_zero;
    e.instr      = m_instr;
    e.pc         = m_idpc;
    e.pc4        = m_idpc4;
    exp_q.push_back(e);

    if (r) begin
      model_reset();
    end else if (rd) begin
      m_pc       = rpc & ~32'h3;
      m_vld      = 1'b0;
      m_buf_full = 1'b0;
      m_idle     = 1'b0;
    end else if (m_idle) begin
      m_idle = 1'b0;
    end else if (m_buf_full) begin
      if (!s) begin
        model_deliver(m_buf_instr, m_buf_pc);
        m_pc       = m_buf_pc + 32'd4;
        m_buf_full = 1'b0;
      end
    end else if (s) begin
      if (rdy) begin
        m_buf_full  = 1'b1;
        m_buf_instr = word_at(m_pc);
        m_buf_pc    = m_pc;
      end
    end else if (rdy) begin
      model_deliver(word_at(m_pc), m_pc);
      m_pc = m_pc + 32'd4;
    end else begin
      m_vld = 1'b0;
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  snap_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("imem_req", {31'h0, imem_req}, {31'h0, mon_e.req});
      check("imem_addr", imem_addr, mon_e.addr);
      check("id_valid", {31'h0, id_valid}, {31'h0, mon_e.vld});
      if (mon_e.cmp_fields) begin
        check("id_instr", id_instr, mon_e.instr);
        check("id_pc", id_pc, mon_e.pc);
        check("id_pc_plus4", id_pc_plus4, mon_e.pc4);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();

    // Reset held: request low, ID cleared.
    repeat (2) cycle(1, 0, 0, 32'h0, 1);

    // Release with memory always ready: one idle cycle, then a word per cycle.
    for (int i = 0; i < 20 && m_pc != 32'h8; i++) cycle(0, 0, 0, 32'h0, 1);

    // Memory not ready for three cycles at 0x8: bubbles, no address skipped.
    repeat (3) cycle(0, 0, 0, 32'h0, 0);
    for (int i = 0; i < 20 && m_pc != 32'h10; i++) cycle(0, 0, 0, 32'h0, 1);

    // Stall while memory ready at 0x10: word parked, then released.
    repeat (2) cycle(0, 1, 0, 32'h0, 1);
    repeat (3) cycle(0, 0, 0, 32'h0, 1);

    // Redirect to an unaligned target while parked and stalled.
    cycle(0, 1, 0, 32'h0, 1);
    cycle(0, 1, 1, 32'h103, 1);
    repeat (3) cycle(0, 0, 0, 32'h0, 1);

    // Redirect to the last word of the address space: PC wraps to 0.
    cycle(0, 0, 1, 32'hFFFF_FFFC, 1);
    repeat (3) cycle(0, 0, 0, 32'h0, 1);

    // Reset pulse mid-stream at 0x40.
    cycle(0, 0, 1, 32'h30, 0);
    for (int i = 0; i < 20 && m_pc != 32'h40; i++) cycle(0, 0, 0, 32'h0, 1);
    cycle(1, 0, 0, 32'h0, 1);
    repeat (4) cycle(0, 0, 0, 32'h0, 1);

    // Randomised traffic: stalls, back-pressure, redirects near the wrap
    // point, and occasional resets landing in any state.
    for (int i = 0; i < 2000; i++) begin
      logic        r, s, rd, rdy;
      logic [31:0] rpc;
      r   = ($urandom_range(63) == 0);
      rd  = ($urandom_range(15) == 0);
      s   = ($urandom_range(3) == 0);
      rdy = ($urandom_range(3) != 0);
      rpc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                     : 32'($urandom);
      cycle(r, s, rd, rpc, rdy);
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
